// File: rtl/mux41_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Channel index i (0=a .. 3=d) maps to the mux select through the
// fixed board wiring: sel = ~i.
package mux41_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] SEL_A = 2'b11;
   localparam logic [1:0] SEL_B = 2'b10;
   localparam logic [1:0] SEL_C = 2'b01;
   localparam logic [1:0] SEL_D = 2'b00;

   // Dwell counter width; covers DWELL up to 255.
   localparam int CNT_W = 8;

   // Translate a channel index into the select code the mux expects.
   function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
      logic [1:0] s;
      case (idx)
         2'd0:    s = SEL_A;
         2'd1:    s = SEL_B;
         2'd2:    s = SEL_C;
         default: s = SEL_D;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mux41_next_ch.sv
// Combinational priority finder: returns the lowest enabled channel
// strictly above idx, or the lowest enabled channel overall when first=1.
module mux41_next_ch
   import mux41_pkg::*;
(
   input  logic [3:0] mask,
   input  logic [1:0] idx,
   input  logic       first,
   output logic       found,
   output logic [1:0] next_idx
);

   logic [3:0] cand;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign cand[gi] = mask[gi] & (first | (2'(gi) > idx));
      end
   endgenerate

   // Pick the lowest-numbered candidate channel.
   always_comb begin
      found    = |cand;
      next_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (cand[i]) next_idx = 2'(i);
      end
   end

endmodule

// File: rtl/mux41_scan_ctrl.sv
// Scan sequencer in front of a 4:1 mux: steps sel through the enabled
// channels, samples mux_out once per channel after a settle delay and
// publishes the four captured bits with a one-cycle done pulse.
module mux41_scan_ctrl
   import mux41_pkg::*;
#(
   parameter int DWELL  = 4,
   parameter int SETTLE = 1
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] ch_mask,
   input  logic       mux_out,
   output logic [1:0] sel,
   output logic       busy,
   output logic       done,
   output logic [3:0] sample,
   output logic       sample_err
);

   localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);

   state_t           state;
   logic [1:0]       idx_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [3:0]       mask_reg;
   logic [3:0]       shadow_reg;
   logic [3:0]       shadow_next;

   logic             first_found;
   logic [1:0]       first_idx;
   logic             adv_found;
   logic [1:0]       adv_idx;

   // First channel of a new scan, taken from the live mask at start.
   mux41_next_ch u_first (
      .mask     (ch_mask),
      .idx      (2'd0),
      .first    (1'b1),
      .found    (first_found),
      .next_idx (first_idx)
   );

   // Next channel during a scan, taken from the latched mask.
   mux41_next_ch u_adv (
      .mask     (mask_reg),
      .idx      (idx_reg),
      .first    (1'b0),
      .found    (adv_found),
      .next_idx (adv_idx)
   );

   // Shadow with this cycle's capture folded in, so a capture on the
   // last dwell cycle still reaches sample.
   always_comb begin
      shadow_next = shadow_reg;
      if (cnt_reg == CNT_SETTLE) shadow_next[idx_reg] = mux_out;
   end

   // Scan FSM, dwell counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx_reg    <= 2'd0;
         cnt_reg    <= '0;
         mask_reg   <= 4'h0;
         shadow_reg <= 4'h0;
         sel        <= SEL_D;
         busy       <= 1'b0;
         done       <= 1'b0;
         sample     <= 4'h0;
         sample_err <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               sel   <= SEL_D;
               busy  <= 1'b0;
               if (start) begin
                  mask_reg   <= ch_mask;
                  shadow_reg <= 4'h0;
                  sample_err <= 1'b0;
                  cnt_reg    <= '0;
                  if (first_found) begin
                     idx_reg <= first_idx;
                     sel     <= idx_to_sel(first_idx);
                     busy    <= 1'b1;
                     state   <= SCAN;
                  end else begin
                     // Empty mask: report an all-zero result immediately.
                     state  <= DONE;
                     done   <= 1'b1;
                     sample <= 4'h0;
                  end
               end
            end

            SCAN: begin
               if (start) sample_err <= 1'b1;
               shadow_reg <= shadow_next;
               if (cnt_reg == CNT_LAST) begin
                  cnt_reg <= '0;
                  if (adv_found) begin
                     idx_reg <= adv_idx;
                     sel     <= idx_to_sel(adv_idx);
                  end else begin
                     state   <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     sample  <= shadow_next;
                     sel     <= SEL_D;
                     idx_reg <= 2'd0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               sel   <= SEL_D;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
